sram_burst_reader: RTL and testbench

// - Downstream consumer of the CNN sram (registered read address, data valid the cycle after the address).
// - On a start pulse, reads LEN consecutive words from BASE.
// - Presents them as a valid/ready stream to the next CNN stage (MAC array / line buffer).
// - A 2-entry output FIFO absorbs the in-flight read, so backpressure never loses or duplicates a word.
// - Full throughput: 1 word/cycle while out_ready is held high.

---
 rtl/sram_burst_reader_if.sv | 37 +++
 rtl/sram_burst_reader.sv | 116 +++++++++++
 tb/tb_sram_burst_reader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_burst_reader_if.sv
// Bus bundle for sram_burst_reader: burst control, sram read port and output stream.
// The optional stride input exists only when SRAM_BURST_STRIDE_EN is defined.
interface sram_burst_reader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 9
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  burst_len;
`ifdef SRAM_BURST_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride;
`endif
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] sram_rd_addr;
  logic [DATA_WIDTH-1:0] sram_rd_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  modport master (
`ifdef SRAM_BURST_STRIDE_EN
    input  stride,
`endif
    input  start, base_addr, burst_len, sram_rd_data, out_ready,
    output busy, done, sram_rd_addr, out_valid, out_data
  );

  modport slave (
`ifdef SRAM_BURST_STRIDE_EN
    output stride,
`endif
    output start, base_addr, burst_len, sram_rd_data, out_ready,
    input  busy, done, sram_rd_addr, out_valid, out_data
  );
endinterface

// File: rtl/sram_burst_reader.sv
// Burst reader: streams burst_len sram words from base_addr through a 2-entry FIFO.
// Define SRAM_BURST_STRIDE_EN to add a per-burst address stride (default step is 1).
module sram_burst_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 9
) (
  input logic                 clk,
  input logic                 rst,
  sram_burst_reader_if.master bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] DONE_ST = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [ADDR_WIDTH-1:0] step;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [1:0]            occupancy;
  logic                  out_valid_w;
  logic                  pop;
  logic                  issue_ok;
  logic                  issue;

  assign out_valid_w = (count != 2'd0);
  assign pop         = out_valid_w && bus.out_ready;
  // A read may be issued if its word has a free slot on arrival, counting the one in flight.
  assign occupancy   = count + {1'b0, vld_p1};
  assign issue_ok    = (occupancy < 2'd2) || pop;
  assign issue       = (state == ISSUE) && issue_ok;

`ifdef SRAM_BURST_STRIDE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      step <= '0;
    else if (state == IDLE && bus.start)
      step <= bus.stride;
  end
`else
  assign step = ADDR_WIDTH'(1);
`endif

  // Stage p0: burst control and sram address issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      addr_p0          <= '0;
      remaining        <= '0;
      bus.sram_rd_addr <= '0;
      vld_p1           <= 1'b0;
    end else begin
      vld_p1 <= issue;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.burst_len != '0) begin
              addr_p0   <= bus.base_addr;
              remaining <= bus.burst_len;
              state     <= ISSUE;
            end else begin
              state <= DONE_ST;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            bus.sram_rd_addr <= addr_p0;
            addr_p0          <= addr_p0 + step;
            remaining        <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1))
              state <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave as the last word is handshaked so done lands on the following cycle.
          if (!vld_p1 && (count == {1'b0, pop}))
            state <= DONE_ST;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: capture the landed sram word into the output FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (vld_p1) begin
        fifo_mem[wr_ptr] <= bus.sram_rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, vld_p1} - {1'b0, pop};
    end
  end

  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = fifo_mem[rd_ptr];
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE_ST);

endmodule

// File: tb/tb_sram_burst_reader.sv
// Directed bench for sram_burst_reader with a combinational-read sram model (mem[i] = i + 100).
module tb_sram_burst_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_burst_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .LEN_WIDTH(9)) bus ();

  sram_burst_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .LEN_WIDTH(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [15:0] mem [256];
  assign bus.sram_rd_data = mem[bus.sram_rd_addr];

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] ev [8];
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Consume one burst; bp selects the 1,0,0,1,0,1 ready pattern, else ready stays high.
  task automatic collect(input string tag, input int n, input bit bp);
    int got = 0;
    bit stall = 1'b0;
    bit seen_done = 1'b0;
    logic [15:0] held = '0;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      bus.out_ready = bp ? pat[c % 6] : 1'b1;
      #1;
      if (stall) check({tag, "_hold"}, {16'd0, bus.out_data}, {16'd0, held});
      if (bus.done) begin
        seen_done = 1'b1;
        check({tag, "_done_after_last"}, got, n);
      end
      stall = bus.out_valid && !bus.out_ready;
      held  = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        if (got < 8) check({tag, "_data"}, {16'd0, bus.out_data}, {16'd0, ev[got]});
        got++;
      end
      step();
    end
    check({tag, "_count"}, got, n);
    check({tag, "_done_seen"}, {31'd0, seen_done}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i + 100);
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.burst_len = '0;
    bus.out_ready = 1'b1;
`ifdef SRAM_BURST_STRIDE_EN
    bus.stride    = 8'd1;
`endif

    step();
    step();
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    check("rst_done",      {31'd0, bus.done},      32'd0);
    check("rst_rd_addr",   {24'd0, bus.sram_rd_addr}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data",  {16'd0, bus.out_data},  32'd0);
    rst = 1'b0;
    step();

    // Cycle-exact burst, no stall
    bus.base_addr = 8'd4;
    bus.burst_len = 9'd5;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    check("ns_busy_e0",  {31'd0, bus.busy},      32'd1);
    check("ns_valid_e0", {31'd0, bus.out_valid}, 32'd0);
    step();
    check("ns_addr_e1",  {24'd0, bus.sram_rd_addr}, 32'd4);
    check("ns_valid_e1", {31'd0, bus.out_valid},    32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("ns_valid", {31'd0, bus.out_valid}, 32'd1);
      check("ns_data",  {16'd0, bus.out_data},  32'(104 + k));
    end
    step();
    check("ns_done",       {31'd0, bus.done},      32'd1);
    check("ns_valid_done", {31'd0, bus.out_valid}, 32'd0);
    step();
    check("ns_done_clr",   {31'd0, bus.done}, 32'd0);
    check("ns_busy_clr",   {31'd0, bus.busy}, 32'd0);

    // Backpressure
    ev = '{16'd104, 16'd105, 16'd106, 16'd107, 16'd108, 16'd0, 16'd0, 16'd0};
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    collect("bp", 5, 1'b1);
    check("bp_idle", {31'd0, bus.busy}, 32'd0);

    // Address wrap
    ev = '{16'd354, 16'd355, 16'd100, 16'd101, 16'd0, 16'd0, 16'd0, 16'd0};
    bus.base_addr = 8'd254;
    bus.burst_len = 9'd4;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    collect("wrap", 4, 1'b0);
    check("wrap_last_addr", {24'd0, bus.sram_rd_addr}, 32'd1);

    // Zero-length burst
    bus.base_addr = 8'd50;
    bus.burst_len = 9'd0;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    check("zl_done",  {31'd0, bus.done}, 32'd1);
    check("zl_busy",  {31'd0, bus.busy}, 32'd1);
    check("zl_addr",  {24'd0, bus.sram_rd_addr}, 32'd1);
    step();
    check("zl_done_clr", {31'd0, bus.done}, 32'd0);
    check("zl_busy_clr", {31'd0, bus.busy}, 32'd0);
    check("zl_addr_held", {24'd0, bus.sram_rd_addr}, 32'd1);

    // Start while busy is ignored
    ev = '{16'd104, 16'd105, 16'd106, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    bus.out_ready = 1'b0;
    bus.base_addr = 8'd4;
    bus.burst_len = 9'd3;
    bus.start     = 1'b1;
    step();
    bus.base_addr = 8'd200;
    bus.burst_len = 9'd7;
    step();
    step();
    bus.start = 1'b0;
    collect("busy_start", 3, 1'b0);
    step();
    check("busy_start_idle",  {31'd0, bus.busy},      32'd0);
    check("busy_start_empty", {31'd0, bus.out_valid}, 32'd0);

    // Reset mid-burst after two handshakes
    bus.out_ready = 1'b1;
    bus.base_addr = 8'd0;
    bus.burst_len = 9'd6;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    check("mr_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mr_busy",  {31'd0, bus.busy},      32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      check("mr_no_done", {31'd0, bus.done}, 32'd0);
    end
    rst = 1'b0;
    step();
    check("mr_no_done_after", {31'd0, bus.done}, 32'd0);
    ev = '{16'd100, 16'd101, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    bus.base_addr = 8'd0;
    bus.burst_len = 9'd2;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    collect("mr_restart", 2, 1'b0);

`ifdef SRAM_BURST_STRIDE_EN
    // Strided burst
    ev = '{16'd100, 16'd103, 16'd106, 16'd109, 16'd0, 16'd0, 16'd0, 16'd0};
    bus.base_addr = 8'd0;
    bus.stride    = 8'd3;
    bus.burst_len = 9'd4;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    collect("stride", 4, 1'b0);
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
